fifo_wr_arbiter: RTL

Round-robin write arbiter that shares a single `fifo_buffer` write port among `N_REQ` producers (PicoBlaze port writes, UART RX, timer event logger, etc.). Each producer presents bytes on a valid/ready handshake. The arbiter grants one producer at a time for a burst that ends on `req_last` or after `MAX_BURST` beats. It drives the FIFO's `wr_en`/`din` and honours its `full` flag so that no byte is dropped.

---
 rtl/fifo_arb_pkg.sv | 24 ++
 rtl/fifo_wr_arbiter_rr_priority_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int MAX_REQ = 8;

    // Reference form of the round-robin pick: first set bit at or above ptr, wrapping at n.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (valid[idx[2:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// Rotate the request vector so rr_ptr sits at bit 0, priority-encode, then rotate the index back.
module rr_priority_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   pick
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    int                 off;
    int                 sum;

    always_comb begin
        dbl = {valid, valid} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        // Explicit wrap keeps non-power-of-2 N_REQ correct.
        sum = int'(ptr) + off;
        if (sum >= N_REQ) sum = sum - N_REQ;
        pick = IDW'(sum);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        fifo_wr_en,
    output logic [DATA_WIDTH-1:0]       fifo_din,
    input  logic                        fifo_full,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int BW  = $clog2(MAX_BURST + 1);

    arb_state_t      state, state_nxt;
    logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0]  grant_nxt;
    logic [BW-1:0]   beat_cnt, beat_nxt;
    logic [IDW-1:0]  pick_id;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .pick  (pick_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= grant_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_id;
        beat_nxt   = beat_cnt;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_nxt = pick_id;
                    beat_nxt  = '0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                req_ready[grant_id] = !fifo_full;
                fifo_wr_en          = req_valid[grant_id] && !fifo_full;
                // req_last only steers the next state, never an output.
                if (fifo_wr_en) begin
                    beat_nxt = beat_cnt + BW'(1);
                    if (req_last[grant_id] || (beat_cnt == BW'(MAX_BURST - 1))) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fifo_din = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign busy     = (state == BURST);

endmodule
